// File: rtl/tpu_matmul_sequencer.sv
// Command sequencer for one matrix multiply on the 32x32 systolic core:
// weight pop/load, activation address stream, drain wait, result readout.
module tpu_matmul_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 32,
  parameter int TIMEOUT     = 256,
  parameter int CNT_BW      = 9
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDRESSSIZE-1:0] cmd_act_base,
  input  logic [ADDRESSSIZE-1:0] cmd_res_base,
  input  logic [ADDRESSSIZE-1:0] cmd_rows,
  input  logic                   abort,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   mul_start,
  output logic [ADDRESSSIZE-1:0] act_address,
  output logic                   valid_address,
  input  logic                   array_end,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   res_valid,
  output logic                   busy,
  output logic                   wait_weight,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    IDLE, WPOP, WLOAD, STREAM, DRAIN, RDOUT, DONE
  } state_t;

  state_t                 state, state_n;
  logic [ADDRESSSIZE-1:0] act_base_q, act_base_n;
  logic [ADDRESSSIZE-1:0] res_base_q, res_base_n;
  logic [ADDRESSSIZE-1:0] act_n, res_n;
  logic [CNT_BW-1:0]      rows_q, rows_n;
  logic [CNT_BW-1:0]      row_cnt, row_cnt_n;
  logic [CNT_BW-1:0]      tmo_cnt, tmo_cnt_n;
  logic                   err_n;
  logic                   rows_ok;
  logic                   last_row;

  assign rows_ok  = (cmd_rows != '0) && (cmd_rows <= ADDRESSSIZE'(MATRIX_SIZE));
  assign last_row = (row_cnt == rows_q - CNT_BW'(1));

  always_comb begin
    state_n    = state;
    act_base_n = act_base_q;
    res_base_n = res_base_q;
    rows_n     = rows_q;
    act_n      = act_address;
    res_n      = res_address;
    row_cnt_n  = row_cnt;
    tmo_cnt_n  = tmo_cnt;
    err_n      = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (rows_ok) begin
              act_base_n = cmd_act_base;
              res_base_n = cmd_res_base;
              rows_n     = CNT_BW'(cmd_rows);
              state_n    = WPOP;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        // The pop is committed on the edge that sees the FIFO non-empty,
        // so the registered pop strobe itself marks the last WPOP cycle.
        WPOP: begin
          if (fifo_read_enable) state_n = WLOAD;
        end
        WLOAD: begin
          state_n   = STREAM;
          act_n     = act_base_q;
          row_cnt_n = '0;
        end
        STREAM: begin
          if (last_row) begin
            state_n   = DRAIN;
            tmo_cnt_n = '0;
          end else begin
            act_n     = act_address + ADDRESSSIZE'(1);
            row_cnt_n = row_cnt + CNT_BW'(1);
          end
        end
        DRAIN: begin
          if (array_end) begin
            state_n   = RDOUT;
            res_n     = res_base_q;
            row_cnt_n = '0;
          end else if (tmo_cnt == CNT_BW'(TIMEOUT - 1)) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            tmo_cnt_n = tmo_cnt + CNT_BW'(1);
          end
        end
        RDOUT: begin
          if (last_row) begin
            state_n = DONE;
          end else begin
            res_n     = res_address + ADDRESSSIZE'(1);
            row_cnt_n = row_cnt + CNT_BW'(1);
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered images of the next state so every strobe lines
  // up with the state it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      act_base_q       <= '0;
      res_base_q       <= '0;
      rows_q           <= '0;
      row_cnt          <= '0;
      tmo_cnt          <= '0;
      act_address      <= '0;
      res_address      <= '0;
      cmd_ready        <= 1'b1;
      busy             <= 1'b0;
      wait_weight      <= 1'b0;
      fifo_read_enable <= 1'b0;
      we_rl            <= 1'b0;
      mul_start        <= 1'b0;
      valid_address    <= 1'b0;
      res_valid        <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= state_n;
      act_base_q       <= act_base_n;
      res_base_q       <= res_base_n;
      rows_q           <= rows_n;
      row_cnt          <= row_cnt_n;
      tmo_cnt          <= tmo_cnt_n;
      act_address      <= act_n;
      res_address      <= res_n;
      cmd_ready        <= (state_n == IDLE);
      busy             <= (state_n != IDLE);
      wait_weight      <= (state_n == WPOP) && fifo_empty;
      fifo_read_enable <= (state_n == WPOP) && !fifo_empty;
      we_rl            <= (state_n == WLOAD);
      mul_start        <= (state_n inside {WLOAD, STREAM, DRAIN});
      valid_address    <= (state_n == STREAM);
      res_valid        <= (state_n == RDOUT);
      done             <= (state_n == DONE);
      err              <= err_n;
    end
  end

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Randomized bench for tpu_matmul_sequencer: a phase-list model of each
// command's output trace is compared against the DUT cycle by cycle.
module tb_tpu_matmul_sequencer;
  localparam int AW  = 10;
  localparam int MS  = 32;
  localparam int TMO = 256;
  localparam int CW  = 9;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_act_base = '0;
  logic [AW-1:0] cmd_res_base = '0;
  logic [AW-1:0] cmd_rows = '0;
  logic          abort = 1'b0;
  logic          fifo_empty = 1'b0;
  logic          fifo_read_enable;
  logic          we_rl;
  logic          mul_start;
  logic [AW-1:0] act_address;
  logic          valid_address;
  logic          array_end = 1'b0;
  logic [AW-1:0] res_address;
  logic          res_valid;
  logic          busy;
  logic          wait_weight;
  logic          done;
  logic          err;

  tpu_matmul_sequencer #(
    .ADDRESSSIZE(AW), .MATRIX_SIZE(MS), .TIMEOUT(TMO), .CNT_BW(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_act_base(cmd_act_base), .cmd_res_base(cmd_res_base), .cmd_rows(cmd_rows),
    .abort(abort), .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable),
    .we_rl(we_rl), .mul_start(mul_start), .act_address(act_address),
    .valid_address(valid_address), .array_end(array_end), .res_address(res_address),
    .res_valid(res_valid), .busy(busy), .wait_weight(wait_weight), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          cmd_ready;
    logic          busy;
    logic          wait_weight;
    logic          fifo_read_enable;
    logic          we_rl;
    logic          mul_start;
    logic          valid_address;
    logic [AW-1:0] act_address;
    logic          res_valid;
    logic [AW-1:0] res_address;
    logic          done;
    logic          err;
  } outv_t;

  outv_t         exp_q[$];
  outv_t         obs_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [AW-1:0] m_act = '0;
  logic [AW-1:0] m_res = '0;

  function automatic outv_t mk(bit bz, bit wt, bit pop, bit ld, bit ms, bit va,
                               bit rv, bit dn, bit er);
    outv_t v;
    v.cmd_ready = !bz;  v.busy = bz;  v.wait_weight = wt;
    v.fifo_read_enable = pop;  v.we_rl = ld;  v.mul_start = ms;
    v.valid_address = va;  v.act_address = m_act;
    v.res_valid = rv;  v.res_address = m_res;
    v.done = dn;  v.err = er;
    return v;
  endfunction

  function automatic outv_t sample();
    outv_t v;
    v.cmd_ready = cmd_ready;  v.busy = busy;  v.wait_weight = wait_weight;
    v.fifo_read_enable = fifo_read_enable;  v.we_rl = we_rl;  v.mul_start = mul_start;
    v.valid_address = valid_address;  v.act_address = act_address;
    v.res_valid = res_valid;  v.res_address = res_address;
    v.done = done;  v.err = err;
    return v;
  endfunction

  // Expected trace, one entry per cycle after the accept edge:
  // nw wait cycles, pop, load, rows stream, drain, rows readout, done, idle.
  // d == 0 means array_end never comes; ab_cyc >= 0 is the edge sampling abort.
  task automatic build_cmd(input logic [AW-1:0] ab, input logic [AW-1:0] rb,
                           input int rows, input int nw, input int d, input int ab_cyc);
    exp_q.delete();
    repeat (nw) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < rows; k++) begin
      m_act = ab + AW'(k);
      exp_q.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    end
    for (int j = 0; j < ((d == 0) ? TMO : d); j++)
      exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    if (d == 0) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end else begin
      for (int k = 0; k < rows; k++) begin
        m_res = rb + AW'(k);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
      end
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    if (ab_cyc >= 1) begin
      while (exp_q.size() > ab_cyc) void'(exp_q.pop_back());
      m_act = exp_q[$].act_address;
      m_res = exp_q[$].res_address;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // Drives one command; inputs the DUT must ignore are randomized.
  task automatic run_cmd(input logic [AW-1:0] ab, input logic [AW-1:0] rb, input int rows,
                         input int nw, input int d, input bit early, input int ab_cyc);
    int ds;
    build_cmd(ab, rb, rows, nw, d, ab_cyc);
    obs_q.delete();
    ds = nw + 2 + rows;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c == 0) begin
        cmd_valid = 1'b1;  cmd_act_base = ab;  cmd_res_base = rb;  cmd_rows = AW'(rows);
      end else begin
        cmd_valid    = exp_q[c-1].busy ? 1'($urandom % 2) : 1'b0;
        cmd_act_base = AW'($urandom);
        cmd_res_base = AW'($urandom);
        cmd_rows     = AW'($urandom_range(0, 40));
      end
      fifo_empty = (c < nw) ? 1'b1 : (c == nw) ? 1'b0 : 1'($urandom % 2);
      if (d == 0)
        array_end = (c > ds) ? 1'b0 : 1'($urandom % 2);
      else if (c > ds && c < ds + d)
        array_end = 1'b0;
      else if (c == ds + d || (early && c == ds))
        array_end = 1'b1;
      else
        array_end = 1'($urandom % 2);
      abort = (c == ab_cyc);
      @(posedge clk);
      @(negedge clk);
      obs_q.push_back(sample());
    end
    cmd_valid = 1'b0;  abort = 1'b0;  array_end = 1'b0;  fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    outv_t want;
    m_act = '0;  m_res = '0;
    want = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (sample() !== want) begin
      miscompares++;
      $display("FAIL reset got %h want %h", sample(), want);
    end
    rstn = 1'b1;
  endtask

  task automatic test_full_tile();
    run_cmd(10'd0, 10'd0, 32, 0, 40, 1'b0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_tile cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_weight_wait();
    run_cmd(10'd100, 10'd200, 6, 5, 3, 1'b0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL weight_wait cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    run_cmd(10'd1020, 10'd1019, 8, 0, 2, 1'b0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL addr_wrap cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_early_end();
    run_cmd(10'd400, 10'd500, 1, 0, 1, 1'b1, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL early_end cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal_rows();
    logic [AW-1:0] bad[4];
    outv_t got, want_err, want_idle;
    bad[0] = 10'd0;  bad[1] = 10'd33;  bad[2] = AW'($urandom_range(34, 1023));  bad[3] = 10'd1023;
    want_err  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    want_idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;  cmd_rows = bad[i];  fifo_empty = 1'b0;
      cmd_act_base = AW'($urandom);  cmd_res_base = AW'($urandom);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      got = sample();
      vectors++;
      if (got !== want_err) begin
        miscompares++;
        $display("FAIL illegal_err rows=%0d got %h want %h", bad[i], got, want_err);
      end
      @(posedge clk);
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== want_idle) begin
        miscompares++;
        $display("FAIL illegal_after rows=%0d got %h want %h", bad[i], got, want_idle);
      end
    end
  endtask

  task automatic test_timeout();
    run_cmd(10'd5, 10'd7, 4, 0, 0, 1'b0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL timeout cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    outv_t got, want;
    // abort sampled on the edge ending the 10th stream cycle
    run_cmd(10'd50, 10'd60, 16, 0, 10, 1'b0, 12);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_stream cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    run_cmd(10'd300, 10'd400, 16, 1, 5, 1'b0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_resume cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    // abort beats acceptance of legal and illegal commands in IDLE
    want = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1;  abort = 1'b1;  cmd_rows = (i == 0) ? 10'd4 : 10'd0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;  abort = 1'b0;
      @(posedge clk);
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL abort_idle case%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rows, nw, d, ac;
    for (int n = 0; n < 25; n++) begin
      rows = $urandom_range(1, MS);
      nw   = $urandom_range(0, 4);
      d    = $urandom_range(1, 20);
      ac   = ($urandom % 5 == 0) ? $urandom_range(1, nw + 2 + rows + d) : -1;
      run_cmd(AW'($urandom), AW'($urandom), rows, nw, d, d == 1, ac);
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b cmd%0d cyc%0d got %h want %h", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_midop_reset();
    outv_t got, want;
    cmd_valid = 1'b1;  cmd_act_base = 10'd77;  cmd_res_base = 10'd5;  cmd_rows = 10'd8;
    fifo_empty = 1'b0;  abort = 1'b0;  array_end = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (act_address !== 10'd79 || valid_address !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_pre got act=%0d va=%b want act=79 va=1", act_address, valid_address);
    end
    m_act = '0;  m_res = '0;
    want = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1 got = sample();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL midop_reset got %h want %h", got, want);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_weight_wait();
    test_addr_wrap();
    test_early_end();
    test_illegal_rows();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_midop_reset();
    test_full_tile();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpu_matmul_sequencer.md
Name: tpu_matmul_sequencer

Overview:
- Command-driven controller that sequences one matrix multiply on the 32x32 systolic TPU core.
- Per command it:
  - pops one weight tile from the weight FIFO and pulses the weight-load strobe;
  - streams activation SRAM addresses with a valid qualifier;
  - waits for the array end indication;
  - walks the result SRAM read addresses.
- Sits between the host/command interface and TOP_tpu, replacing manual strobe sequencing.

Parameters:
ADDRESSSIZE, 10, width of activation and result SRAM addresses
MATRIX_SIZE, 32, max rows per command (array dimension)
TIMEOUT, 256, max cycles waited in DRAIN for array end before abort
CNT_BW, 9, width of internal row/timeout counters (must hold TIMEOUT)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid&cmd_ready
cmd_act_base  in  ADDRESSSIZE  first activation SRAM address
cmd_res_base  in  ADDRESSSIZE  first result SRAM address
cmd_rows  in  ADDRESSSIZE  activation rows to stream, legal 1..MATRIX_SIZE
abort  in  1  synchronous abort
fifo_empty  in  1  weight FIFO empty flag
fifo_read_enable  out  1  one-cycle weight FIFO pop
we_rl  out  1  one-cycle weight-load strobe to array
mul_start  out  1  array run enable
act_address  out  ADDRESSSIZE  activation SRAM address
valid_address  out  1  act_address qualifier
array_end  in  1  end indication from array (level)
res_address  out  ADDRESSSIZE  result SRAM read address
res_valid  out  1  res_address qualifier
busy  out  1  high in any state except IDLE
wait_weight  out  1  high while stalled in WPOP on fifo_empty
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: illegal cmd_rows or DRAIN timeout

Behaviour:
- Reset values:
  - cmd_ready=1.
  - act_address=0, res_address=0.
  - All other outputs 0.
  - State=IDLE, counters 0.
- All outputs are registered; they change only on rising clk.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_rows in 1..MATRIX_SIZE: latch bases and rows, go WPOP.
  - On accept with cmd_rows=0 or >MATRIX_SIZE: err pulse next cycle, stay IDLE, nothing latched.
- WPOP:
  - If fifo_empty: wait_weight=1 and stay; there is no timeout here.
  - Otherwise: fifo_read_enable=1 for exactly one cycle, go WLOAD.
- WLOAD:
  - we_rl=1 for exactly one cycle; this cycle directly follows the pop cycle (FIFO read latency 1).
  - mul_start rises in this cycle and stays high through STREAM and DRAIN.
  - Go STREAM.
- STREAM:
  - valid_address=1 for exactly cmd_rows consecutive cycles.
  - act_address = act_base + k, k = 0..rows-1, modulo 2^ADDRESSSIZE (wraps, no error).
  - After the last address go DRAIN; valid_address=0 and act_address holds its last value.
- DRAIN:
  - mul_start=1 while waiting.
  - Timeout counter starts at 0 on entry.
  - array_end sampled high: mul_start drops next cycle, go RDOUT.
  - Counter reaches TIMEOUT-1 without array_end: err pulse, mul_start=0, go IDLE with no done.
  - array_end already high on DRAIN entry is accepted on the first DRAIN cycle.
- RDOUT:
  - res_valid=1 for cmd_rows cycles.
  - res_address = res_base + k, wrapping modulo 2^ADDRESSSIZE.
  - Then go DONE.
- DONE:
  - done=1 for one cycle, go IDLE; cmd_ready returns the following cycle.
  - Back-to-back commands are therefore separated by at least one IDLE cycle.
- Abort:
  - In any state, abort=1 forces IDLE on the next edge.
  - All strobes/qualifiers drop to 0; addresses hold; no done, no err.
  - Abort takes priority over every transition, including cmd accept in IDLE.
  - An abort in WLOAD after the FIFO pop loses that weight tile; this is documented and intended.
- Nominal latency, accept edge to done pulse: 1 (WPOP) + 1 (WLOAD) + rows + D (DRAIN cycles incl. end) + rows + 1.
- Mid-operation reset: async clear to the reset values above, immediately.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
1. FIFO holding 1 tile; cmd act_base=0, res_base=0, rows=32; array_end after 40 DRAIN cycles:
   - fifo_read_enable one cycle, then we_rl the next cycle.
   - valid_address 32 cycles with act_address 0..31.
   - res_valid 32 cycles with res_address 0..31.
   - Single done pulse; no err.
2. FIFO empty at accept, tile written 5 cycles later:
   - wait_weight=1 for 5 cycles, fifo_read_enable=0 throughout.
   - Pop the cycle after fifo_empty falls; sequence then completes normally.
3. act_base=1020, rows=8, ADDRESSSIZE=10:
   - act_address 1020,1021,1022,1023,0,1,2,3; no err.
4. cmd_rows=0, then cmd_rows=33:
   - Each gives a single err pulse with busy=0 throughout.
   - No FIFO pop, we_rl, or valid_address.
5. array_end never asserted, TIMEOUT=256:
   - mul_start high for exactly 256 DRAIN cycles, then err pulse, return to IDLE.
   - No res_valid and no done.
6. abort asserted on the 10th STREAM cycle:
   - Next edge: valid_address=0, mul_start=0, busy=0, cmd_ready=1; no done.
   - A new command immediately after runs correctly with a fresh tile.
